// File: rtl/sdram_burst_adapter_if.sv
// User-side request/response bus of the SDRAM burst adapter.
// The master issues line requests; the slave (adapter) answers with one completion pulse.
interface sdram_burst_adapter_if #(
  parameter int WORD_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 24
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_wr;
  logic [ADDR_W-1:0]             req_addr;
  logic [BURST_LEN*WORD_W-1:0]   req_wdata;
  logic [BURST_LEN-1:0]          req_wmask;
  logic                          rsp_valid;
  logic                          rsp_err;
  logic [BURST_LEN*WORD_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/sdram_burst_adapter.sv
// Line-oriented front end for the SDRAM FIFO controller: streams a BURST_LEN-word line
// into the write FIFO or collects one from the read FIFO, with refresh yield and timeout.
module sdram_burst_adapter #(
  parameter int WORD_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 24,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_done_i,
  sdram_burst_adapter_if.slave req_if,
  output logic                 ctl_load_o,
  output logic [ADDR_W-1:0]    ctl_addr_o,
  output logic                 ctl_wr_en_o,
  output logic [WORD_W-1:0]    ctl_wr_data_o,
  output logic                 ctl_wr_dqm_o,
  output logic                 ctl_read_valid_o,
  output logic                 ctl_rd_en_o,
  input  logic [WORD_W-1:0]    ctl_rd_data_i,
  input  logic                 ctl_wr_done_i,
  input  logic                 ctl_rd_done_i,
  input  logic                 ctl_rfsh_pend_i,
  input  logic                 ctl_idle_i
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int TMO_W  = $clog2(TIMEOUT);
  localparam int LINE_W = BURST_LEN * WORD_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RFSH, S_LOAD, S_WR_BEAT, S_WR_WAIT, S_RD_WAIT, S_RD_BEAT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                err_q, err_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [BURST_LEN-1:0] wmask_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                accept;
  logic [WORD_W-1:0]   wword [BURST_LEN];
  logic [WORD_W-1:0]   rword_q [BURST_LEN];

  assign req_if.req_ready = (state_q == S_IDLE) && init_done_i && !ctl_rfsh_pend_i;
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign ctl_addr_o       = addr_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a done pulse is tested before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (init_done_i && ctl_rfsh_pend_i) state_d = S_RFSH;
        else if (accept)                    state_d = S_LOAD;
      end
      S_RFSH:    if (!ctl_rfsh_pend_i && ctl_idle_i) state_d = S_IDLE;
      S_LOAD: begin
        err_d   = 1'b0;
        state_d = wr_q ? S_WR_BEAT : S_RD_WAIT;
      end
      S_WR_BEAT: if (beat_q == LAST_BEAT) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (ctl_wr_done_i) state_d = S_DONE;
        else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (ctl_rd_done_i) state_d = S_RD_BEAT;
        else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RD_BEAT: if (beat_q == LAST_BEAT) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ctl_load_o       = (state_q == S_LOAD);
    ctl_wr_en_o      = (state_q == S_WR_BEAT);
    ctl_wr_data_o    = '0;
    ctl_wr_dqm_o     = 1'b0;
    ctl_read_valid_o = (state_q == S_RD_WAIT) && !ctl_rd_done_i;
    ctl_rd_en_o      = ((state_q == S_RD_WAIT) && ctl_rd_done_i) ||
                       ((state_q == S_RD_BEAT) && (beat_q != LAST_BEAT));
    req_if.rsp_valid = (state_q == S_DONE);
    req_if.rsp_err   = (state_q == S_DONE) && err_q;
    if (state_q == S_WR_BEAT) begin
      ctl_wr_data_o = wword[beat_q];
      ctl_wr_dqm_o  = ~wmask_q[beat_q];
    end
  end

  always_comb begin
    beat_d = beat_q;
    tmo_d  = '0;
    if (state_q == S_LOAD)                                   beat_d = '0;
    else if (state_q == S_WR_BEAT || state_q == S_RD_BEAT)   beat_d = beat_q + 1'b1;
    if (state_q == S_WR_WAIT || state_q == S_RD_WAIT)        tmo_d  = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      beat_q <= beat_d;
      tmo_q  <= tmo_d;
      if (accept) begin
        wr_q    <= req_if.req_wr;
        addr_q  <= req_if.req_addr & ALIGN_MASK;
        wdata_q <= req_if.req_wdata;
        wmask_q <= req_if.req_wmask;
      end
    end
  end

  // Per-word views of the line; a timed-out read never reaches RD_BEAT so rdata holds.
  for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_word
    assign wword[gi] = wdata_q[gi*WORD_W +: WORD_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                  rword_q[gi] <= '0;
      else if (state_q == S_RD_BEAT && beat_q == BEAT_W'(gi))   rword_q[gi] <= ctl_rd_data_i;
    end

    assign req_if.rsp_rdata[gi*WORD_W +: WORD_W] = rword_q[gi];
  end

endmodule

// File: tb/tb_sdram_burst_adapter.sv
// Directed bench: an 8-word/TIMEOUT=16 adapter for line traffic, refresh and timeout,
// plus a 4-word adapter for the mid-burst reset case.
module tb_sdram_burst_adapter;
  localparam int W   = 16;
  localparam int AW  = 24;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [15:0] base);
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = base + 16'(i);
    return l;
  endfunction

  // ---------------- DUT A: BURST_LEN=8 ----------------
  sdram_burst_adapter_if #(.WORD_W(W), .BURST_LEN(8), .ADDR_W(AW)) a_if();
  logic          a_init = 0, a_load, a_wr_en, a_dqm, a_rv, a_rd_en;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_wr_data;
  logic [W-1:0]  a_rd_data = '0;
  logic          a_wr_done = 0, a_rd_done = 0, a_pend = 0, a_idle = 1;

  sdram_burst_adapter #(.WORD_W(W), .BURST_LEN(8), .ADDR_W(AW), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .init_done_i(a_init), .req_if(a_if),
    .ctl_load_o(a_load), .ctl_addr_o(a_addr), .ctl_wr_en_o(a_wr_en),
    .ctl_wr_data_o(a_wr_data), .ctl_wr_dqm_o(a_dqm), .ctl_read_valid_o(a_rv),
    .ctl_rd_en_o(a_rd_en), .ctl_rd_data_i(a_rd_data), .ctl_wr_done_i(a_wr_done),
    .ctl_rd_done_i(a_rd_done), .ctl_rfsh_pend_i(a_pend), .ctl_idle_i(a_idle)
  );

  // Read FIFO model: data appears one cycle after each pop.
  logic [15:0] rd_mem [8];
  logic [2:0]  rd_ptr = '0;
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_rd_data <= rd_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 3'd1;
    end
  end

  logic [16:0] a_push_q [$];
  int a_pops = 0, a_rsp = 0, a_loads = 0, a_acc_cyc = 0, a_first_push_cyc = 0;
  always @(posedge clk) begin
    if (a_if.req_valid && a_if.req_ready) a_acc_cyc <= cyc;
    if (a_wr_en) begin
      if (a_push_q.size() == 0) a_first_push_cyc <= cyc;
      a_push_q.push_back({a_dqm, a_wr_data});
    end
    if (a_rd_en)         a_pops  <= a_pops + 1;
    if (a_if.rsp_valid)  a_rsp   <= a_rsp + 1;
    if (a_load)          a_loads <= a_loads + 1;
  end

  // ---------------- DUT B: BURST_LEN=4 ----------------
  sdram_burst_adapter_if #(.WORD_W(W), .BURST_LEN(4), .ADDR_W(AW)) b_if();
  logic          b_init = 0, b_load, b_wr_en, b_dqm, b_rv, b_rd_en;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_wr_data;
  logic [W-1:0]  b_rd_data = '0;
  logic          b_wr_done = 0, b_rd_done = 0, b_pend = 0, b_idle = 1;

  sdram_burst_adapter #(.WORD_W(W), .BURST_LEN(4), .ADDR_W(AW), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .init_done_i(b_init), .req_if(b_if),
    .ctl_load_o(b_load), .ctl_addr_o(b_addr), .ctl_wr_en_o(b_wr_en),
    .ctl_wr_data_o(b_wr_data), .ctl_wr_dqm_o(b_dqm), .ctl_read_valid_o(b_rv),
    .ctl_rd_en_o(b_rd_en), .ctl_rd_data_i(b_rd_data), .ctl_wr_done_i(b_wr_done),
    .ctl_rd_done_i(b_rd_done), .ctl_rfsh_pend_i(b_pend), .ctl_idle_i(b_idle)
  );

  logic [16:0] b_push_q [$];
  int b_rsp = 0;
  always @(posedge clk) begin
    if (b_wr_en)        b_push_q.push_back({b_dqm, b_wr_data});
    if (b_if.rsp_valid) b_rsp <= b_rsp + 1;
  end

  // ---------------- helpers ----------------
  task automatic a_send(input logic wr, input logic [AW-1:0] addr,
                        input logic [127:0] wdata, input logic [7:0] mask);
    int t;
    t = 0;
    @(negedge clk);
    a_if.req_valid = 1'b1; a_if.req_wr = wr; a_if.req_addr = addr;
    a_if.req_wdata = wdata; a_if.req_wmask = mask;
    while (!a_if.req_ready && t < 50) begin @(negedge clk); t++; end
    check_eq("accept_wait", 128'(t < 50), 128'(1));
    @(negedge clk);
    a_if.req_valid = 1'b0;
  endtask

  task automatic a_wait_pushes(input int n);
    int t;
    t = 0;
    while (a_push_q.size() < n && t < 40) begin @(negedge clk); t++; end
    check_eq("push_count", 128'(a_push_q.size()), 128'(n));
  endtask

  task automatic a_check_pushes(input string tag, input logic [127:0] line, input logic [7:0] dqm_exp);
    for (int i = 0; i < 8 && i < a_push_q.size(); i++)
      check_eq($sformatf("%s_w%0d", tag, i), 128'(a_push_q[i]), 128'({dqm_exp[i], line[i*16 +: 16]}));
  endtask

  task automatic a_read_done_and_wait(output int pops);
    int t, p0;
    t = 0;
    p0 = a_pops;
    while (!a_rv && t < 20) begin @(negedge clk); t++; end
    check_eq("rv_wait", 128'(a_rv), 128'(1));
    @(negedge clk);
    a_rd_done = 1'b1;
    #1;
    check_eq("rd_done_rv", 128'(a_rv), 128'(0));
    check_eq("rd_done_pop", 128'(a_rd_en), 128'(1));
    @(negedge clk);
    a_rd_done = 1'b0;
    t = 0;
    while (!a_if.rsp_valid && t < 30) begin @(negedge clk); t++; end
    check_eq("rd_rsp_valid", 128'(a_if.rsp_valid), 128'(1));
    check_eq("rd_rsp_err", 128'(a_if.rsp_err), 128'(0));
    pops = a_pops - p0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line1, line2, line3;
    logic [63:0]  b_line;
    int pops, t, rv_cnt, rsp0;

    a_if.req_valid = 0; a_if.req_wr = 0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.req_wmask = '0;
    b_if.req_valid = 0; b_if.req_wr = 0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.req_wmask = '0;
    line1 = mk_line(16'h1000);
    line2 = mk_line(16'h2000);
    line3 = mk_line(16'h3000);

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", 128'(a_if.rsp_valid), 128'(0));
    check_eq("rst_load", 128'(a_load), 128'(0));
    check_eq("rst_wr_en", 128'(a_wr_en), 128'(0));
    check_eq("rst_rv", 128'(a_rv), 128'(0));
    check_eq("rst_rd_en", 128'(a_rd_en), 128'(0));
    check_eq("rst_addr", 128'(a_addr), 128'(0));
    check_eq("rst_rdata", a_if.rsp_rdata, 128'(0));
    rst = 1'b0;

    // init_done low: no ready, no load
    a_if.req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("noinit_ready", 128'(a_if.req_ready), 128'(0));
    check_eq("noinit_loads", 128'(a_loads), 128'(0));
    a_if.req_valid = 1'b0;
    a_init = 1'b1; b_init = 1'b1;
    @(negedge clk);
    check_eq("init_ready", 128'(a_if.req_ready), 128'(1));

    // 1. Full-mask write
    a_push_q.delete();
    a_send(1'b1, 24'h000013, line1, 8'hFF);
    check_eq("t1_load", 128'(a_load), 128'(1));
    check_eq("t1_addr", 128'(a_addr), 128'(24'h000010));
    a_wait_pushes(8);
    a_check_pushes("t1_push", line1, 8'h00);
    check_eq("t1_latency", 128'(a_first_push_cyc - a_acc_cyc), 128'(2));
    a_rd_done = 1'b1;      // stray read-done during WR_WAIT must be ignored
    #1;
    check_eq("t1_stray_rd_en", 128'(a_rd_en), 128'(0));
    @(negedge clk);
    a_rd_done = 1'b0;
    check_eq("t1_no_early_rsp", 128'(a_rsp), 128'(0));
    a_wr_done = 1'b1;
    @(negedge clk);
    a_wr_done = 1'b0;
    check_eq("t1_rsp_valid", 128'(a_if.rsp_valid), 128'(1));
    check_eq("t1_rsp_err", 128'(a_if.rsp_err), 128'(0));
    @(negedge clk);
    check_eq("t1_rsp_pulse", 128'(a_if.rsp_valid), 128'(0));

    // Stray write-done in IDLE is ignored
    a_wr_done = 1'b1;
    @(negedge clk);
    a_wr_done = 1'b0;
    @(negedge clk);
    check_eq("idle_stray_rsp", 128'(a_rsp), 128'(1));

    // 2. Read of the same line
    for (int i = 0; i < 8; i++) rd_mem[i] = 16'h1000 + 16'(i);
    a_send(1'b0, 24'h000010, '0, '0);
    a_read_done_and_wait(pops);
    check_eq("t2_pops", 128'(pops), 128'(8));
    check_eq("t2_rdata", a_if.rsp_rdata, line1);

    // 3. Masked write; done arrives exactly on the timeout terminal cycle and wins
    @(negedge clk);
    a_push_q.delete();
    a_send(1'b1, 24'h000027, line2, 8'b10100101);
    check_eq("t3_addr", 128'(a_addr), 128'(24'h000020));
    a_wait_pushes(8);
    a_check_pushes("t3_push", line2, 8'b01011010);
    repeat (TMO - 1) @(negedge clk);
    check_eq("t3_waiting", 128'(a_if.rsp_valid), 128'(0));
    a_wr_done = 1'b1;
    @(negedge clk);
    a_wr_done = 1'b0;
    check_eq("t3_rsp_valid", 128'(a_if.rsp_valid), 128'(1));
    check_eq("t3_tie_err", 128'(a_if.rsp_err), 128'(0));

    // 4. Refresh yield
    for (int i = 0; i < 8; i++) rd_mem[i] = 16'h3000 + 16'(i);
    @(negedge clk);
    rsp0 = a_loads;
    a_pend = 1'b1; a_idle = 1'b0;
    a_if.req_valid = 1'b1; a_if.req_wr = 1'b0; a_if.req_addr = 24'h000030;
    #1;
    check_eq("t4_ready_pend", 128'(a_if.req_ready), 128'(0));
    repeat (3) @(negedge clk);
    check_eq("t4_no_load", 128'(a_loads - rsp0), 128'(0));
    a_pend = 1'b0;
    @(negedge clk);
    check_eq("t4_rfsh_hold", 128'(a_if.req_ready), 128'(0));
    a_idle = 1'b1;
    @(negedge clk);
    check_eq("t4_ready_after", 128'(a_if.req_ready), 128'(1));
    @(negedge clk);
    a_if.req_valid = 1'b0;
    check_eq("t4_load", 128'(a_load), 128'(1));
    a_read_done_and_wait(pops);
    check_eq("t4_pops", 128'(pops), 128'(8));
    check_eq("t4_rdata", a_if.rsp_rdata, line3);

    // 5. Read timeout: 16 cycles of RD_WAIT, then error completion, rdata untouched
    @(negedge clk);
    rsp0 = a_pops;
    a_send(1'b0, 24'h000048, '0, '0);
    rv_cnt = 0;
    t = 0;
    while (t < 40) begin
      @(negedge clk);
      t++;
      if (a_if.rsp_valid) break;
      if (a_rv) rv_cnt++;
    end
    check_eq("t5_rsp_valid", 128'(a_if.rsp_valid), 128'(1));
    check_eq("t5_wait_cycles", 128'(rv_cnt), 128'(TMO));
    check_eq("t5_rsp_err", 128'(a_if.rsp_err), 128'(1));
    check_eq("t5_rdata_kept", a_if.rsp_rdata, line3);
    check_eq("t5_no_pops", 128'(a_pops - rsp0), 128'(0));

    // 6. BURST_LEN=4 write, reset during beat 2
    b_line = 64'h5003_5002_5001_5000;
    @(negedge clk);
    b_if.req_valid = 1'b1; b_if.req_wr = 1'b1; b_if.req_addr = 24'h000005;
    b_if.req_wdata = b_line; b_if.req_wmask = 4'hF;
    @(negedge clk);
    b_if.req_valid = 1'b0;
    t = 0;
    while (b_push_q.size() < 2 && t < 20) begin @(negedge clk); t++; end
    check_eq("t6_beat2_data", 128'(b_wr_data), 128'(16'h5002));
    rst = 1'b1;
    #1;
    check_eq("t6_rst_wr_en", 128'(b_wr_en), 128'(0));
    check_eq("t6_rst_wr_data", 128'(b_wr_data), 128'(0));
    check_eq("t6_rst_addr", 128'(b_addr), 128'(0));
    check_eq("t6_rst_dqm", 128'(b_dqm), 128'(0));
    check_eq("t6_rst_load", 128'(b_load), 128'(0));
    check_eq("t6_rst_rsp", 128'(b_if.rsp_valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_no_rsp", 128'(b_rsp), 128'(0));
    check_eq("t6_pushes_cut", 128'(b_push_q.size()), 128'(2));

    b_push_q.delete();
    b_line = 64'h4003_4002_4001_4000;
    b_if.req_valid = 1'b1; b_if.req_addr = 24'h000009;
    b_if.req_wdata = b_line; b_if.req_wmask = 4'b1101;
    @(negedge clk);
    b_if.req_valid = 1'b0;
    check_eq("t6_addr", 128'(b_addr), 128'(24'h000008));
    t = 0;
    while (b_push_q.size() < 4 && t < 20) begin @(negedge clk); t++; end
    check_eq("t6_push_count", 128'(b_push_q.size()), 128'(4));
    check_eq("t6_push0", 128'(b_push_q[0]), 128'({1'b0, 16'h4000}));
    check_eq("t6_push1", 128'(b_push_q[1]), 128'({1'b1, 16'h4001}));
    check_eq("t6_push2", 128'(b_push_q[2]), 128'({1'b0, 16'h4002}));
    check_eq("t6_push3", 128'(b_push_q[3]), 128'({1'b0, 16'h4003}));
    b_wr_done = 1'b1;
    @(negedge clk);
    b_wr_done = 1'b0;
    check_eq("t6_rsp_valid", 128'(b_if.rsp_valid), 128'(1));
    check_eq("t6_rsp_err", 128'(b_if.rsp_err), 128'(0));
    @(negedge clk);
    check_eq("t6_rsp_count", 128'(b_rsp), 128'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
